// File: rtl/avalon_slave_mm_regbank.sv
// Avalon-MM slave register bank: RW control registers, captured RO status
// registers, and a sticky W1C interrupt pending/mask pair with a registered irq.
module avalon_slave_mm_regbank #(
  parameter int DATA_W = 32,
  parameter int N_RW   = 4,
  parameter int N_RO   = 2,
  parameter int ADDR_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   chipselect,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   write,
  input  logic [DATA_W-1:0]      writedata,
  input  logic [DATA_W/8-1:0]    byteenable,
  input  logic                   read,
  output logic [DATA_W-1:0]      readdata,
  output logic                   readdatavalid,
  output logic [N_RW*DATA_W-1:0] ctrl,
  input  logic [N_RO*DATA_W-1:0] status_data,
  input  logic [N_RO-1:0]        status_we,
  input  logic [DATA_W-1:0]      irq_set,
  output logic                   irq
);

  localparam int PEND_A = N_RW + N_RO;
  localparam int MASK_A = N_RW + N_RO + 1;

  logic [DATA_W-1:0] rw_q [N_RW];
  logic [DATA_W-1:0] rw_d [N_RW];
  logic [DATA_W-1:0] ro_q [N_RO];
  logic [DATA_W-1:0] ro_d [N_RO];
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              rdv_q, rdv_d;
  logic              irq_q, irq_d;

  logic              wr_en, rd_en;
  logic [31:0]       addr_ext;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] w1c_clr;
  logic [DATA_W-1:0] rd_mux;

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign addr_ext = 32'(address);

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      be_mask[8*b +: 8] = {8{byteenable[b]}};
    end
  end

  // Read mux looks only at current register values, so a read that coincides
  // with a write or capture returns the pre-update contents.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_RW; i++) begin
      if (addr_ext == 32'(i)) rd_mux = rw_q[i];
    end
    for (int j = 0; j < N_RO; j++) begin
      if (addr_ext == 32'(N_RW + j)) rd_mux = ro_q[j];
    end
    if (addr_ext == 32'(PEND_A)) rd_mux = pend_q;
    if (addr_ext == 32'(MASK_A)) rd_mux = mask_q;
  end

  always_comb begin
    rw_d       = rw_q;
    ro_d       = ro_q;
    mask_d     = mask_q;
    w1c_clr    = '0;
    readdata_d = readdata_q;
    rdv_d      = 1'b0;

    for (int i = 0; i < N_RW; i++) begin
      if (wr_en && addr_ext == 32'(i)) begin
        rw_d[i] = (rw_q[i] & ~be_mask) | (writedata & be_mask);
      end
    end

    for (int j = 0; j < N_RO; j++) begin
      if (status_we[j]) ro_d[j] = status_data[j*DATA_W +: DATA_W];
    end

    if (wr_en && addr_ext == 32'(MASK_A)) begin
      mask_d = (mask_q & ~be_mask) | (writedata & be_mask);
    end
    if (wr_en && addr_ext == 32'(PEND_A)) begin
      w1c_clr = writedata & be_mask;
    end

    if (rd_en) begin
      rdv_d      = 1'b1;
      readdata_d = rd_mux;
    end
  end

  // Set is OR'd in after the clear so a simultaneous set wins.
  assign pend_d = (pend_q & ~w1c_clr) | irq_set;
  assign irq_d  = |(pend_q & mask_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_RW; i++) rw_q[i] <= '0;
      for (int j = 0; j < N_RO; j++) ro_q[j] <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_RW; i++) rw_q[i] <= rw_d[i];
      for (int j = 0; j < N_RO; j++) ro_q[j] <= ro_d[j];
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      irq_q      <= irq_d;
    end
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_ctrl
    assign ctrl[g*DATA_W +: DATA_W] = rw_q[g];
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_avalon_slave_mm_regbank.sv
// Scoreboard bench for avalon_slave_mm_regbank: reads push expected data with a
// due cycle; a negedge monitor pops and compares on every readdatavalid.
module tb_avalon_slave_mm_regbank;

  localparam int DATA_W = 32;
  localparam int N_RW   = 4;
  localparam int N_RO   = 2;
  localparam int ADDR_W = 5;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   chipselect = 1'b0;
  logic [ADDR_W-1:0]      address = '0;
  logic                   write = 1'b0;
  logic [DATA_W-1:0]      writedata = '0;
  logic [DATA_W/8-1:0]    byteenable = '0;
  logic                   read = 1'b0;
  logic [DATA_W-1:0]      readdata;
  logic                   readdatavalid;
  logic [N_RW*DATA_W-1:0] ctrl;
  logic [N_RO*DATA_W-1:0] status_data = '0;
  logic [N_RO-1:0]        status_we = '0;
  logic [DATA_W-1:0]      irq_set = '0;
  logic                   irq;

  avalon_slave_mm_regbank #(
    .DATA_W(DATA_W), .N_RW(N_RW), .N_RO(N_RO), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .byteenable(byteenable), .read(read),
    .readdata(readdata), .readdatavalid(readdatavalid), .ctrl(ctrl),
    .status_data(status_data), .status_we(status_we), .irq_set(irq_set), .irq(irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every readdatavalid must match the oldest expected read, on time.
  always @(negedge clock) begin
    if (readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdv_unexpected: got readdatavalid=1 at cycle %0d expected 0", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("read_cycle", 32'(cyc), 32'(e.due));
        check("read_data", readdata, e.data);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL rdv_missing: got readdatavalid=0 at cycle %0d expected 1 with 0x%08h",
               cyc, e.data);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    status_we = '0; irq_set = '0;
  endtask

  task automatic do_read(input int a, input logic [DATA_W-1:0] exp);
    exp_t e;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = ADDR_W'(a);
    e.data = exp; e.due = cyc + 1;
    exp_q.push_back(e);
    tick();
    idle();
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W/8-1:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = ADDR_W'(a);
    writedata = d; byteenable = be;
    tick();
    idle();
  endtask

  initial begin
    exp_t e;
    tick(); tick();
    reset = 1'b0;
    check("reset_readdata", readdata, '0);
    check("reset_rdv", {31'b0, readdatavalid}, '0);
    check("reset_irq", {31'b0, irq}, '0);
    check("reset_ctrl0", ctrl[31:0], '0);
    do_read(0, 32'h0);

    // Byte-enable write
    do_write(1, 32'hAABBCCDD, 4'b0101);
    check("ctrl1_be", ctrl[63:32], 32'h00BB00DD);
    do_read(1, 32'h00BB00DD);
    do_write(0, 32'h11223344, 4'b1111);
    check("ctrl0_full", ctrl[31:0], 32'h11223344);
    do_write(1, 32'h99000000, 4'b1000);
    check("ctrl1_lane3", ctrl[63:32], 32'h99BB00DD);

    // Streaming reads including unmapped
    do_read(31, 32'h0);
    do_read(0, 32'h11223344);
    do_read(1, 32'h99BB00DD);
    do_read(8, 32'h0);
    tick();

    // Status capture coinciding with a read of the same register
    status_data[31:0] = 32'h12345678;
    status_we = 2'b01;
    do_read(4, 32'h0);
    do_read(4, 32'h12345678);
    do_write(4, 32'hFFFFFFFF, 4'b1111);
    do_read(4, 32'h12345678);
    do_read(5, 32'h0);

    // Simultaneous read and write returns pre-write value
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 5'd2;
    writedata = 32'hCAFEF00D; byteenable = 4'b1111;
    e.data = 32'h0; e.due = cyc + 1; exp_q.push_back(e);
    tick(); idle();
    check("ctrl2_rw", ctrl[95:64], 32'hCAFEF00D);
    do_read(2, 32'hCAFEF00D);
    tick();
    check("readdata_hold", readdata, 32'hCAFEF00D);
    check("rdv_low_idle", {31'b0, readdatavalid}, '0);

    // Interrupt flow via irq_set
    do_write(7, 32'h1, 4'b1111);
    irq_set = 32'h1; tick(); idle();
    check("irq_not_yet", {31'b0, irq}, '0);
    tick();
    check("irq_set_assert", {31'b0, irq}, 32'h1);
    do_read(6, 32'h1);
    do_write(6, 32'h1, 4'b1111);
    check("irq_after_clear_edge", {31'b0, irq}, 32'h1);
    tick();
    check("irq_cleared", {31'b0, irq}, '0);
    do_read(6, 32'h0);

    // Masked pending bit asserts irq only after the mask write
    irq_set = 32'h4; tick(); idle();
    tick(); tick();
    check("irq_masked", {31'b0, irq}, '0);
    do_write(7, 32'h5, 4'b1111);
    check("irq_mask_edge", {31'b0, irq}, '0);
    tick();
    check("irq_mask_assert", {31'b0, irq}, 32'h1);
    do_write(6, 32'h4, 4'b1111);
    tick();
    check("irq_mask_clear", {31'b0, irq}, '0);

    // Set/clear collision on bit 3; disabled lane does not clear
    chipselect = 1'b1; write = 1'b1; address = 5'd6;
    writedata = 32'h8; byteenable = 4'b1111; irq_set = 32'h8;
    tick(); idle();
    do_read(6, 32'h8);
    do_write(6, 32'h8, 4'b1110);
    do_read(6, 32'h8);
    do_write(6, 32'h8, 4'b0001);
    do_read(6, 32'h0);
    do_read(7, 32'h5);

    // Reset coinciding with a read and an irq_set
    irq_set = 32'h1; tick(); idle();
    tick();
    check("irq_pre_reset", {31'b0, irq}, 32'h1);
    reset = 1'b1; chipselect = 1'b1; read = 1'b1; address = 5'd0;
    irq_set = 32'h1; status_we = 2'b11; status_data = {32'hDEAD0001, 32'hDEAD0000};
    tick(); idle();
    reset = 1'b0;
    check("rst_readdata", readdata, '0);
    check("rst_rdv", {31'b0, readdatavalid}, '0);
    check("rst_irq", {31'b0, irq}, '0);
    check("rst_ctrl_lo", ctrl[63:0] == '0 ? 32'h0 : 32'h1, 32'h0);
    check("rst_ctrl_hi", ctrl[127:64] == '0 ? 32'h0 : 32'h1, 32'h0);
    tick();
    check("rst_rdv_after", {31'b0, readdatavalid}, '0);
    do_read(6, 32'h0);
    do_read(4, 32'h0);
    do_read(7, 32'h0);

    tick(); tick(); tick();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
